// File: rtl/sw_alloc_sched.sv
// Switch allocator: per-output wormhole lock, round-robin arbitration and
// credit-based flow control. Grants are combinational; all state is registered.
module sw_alloc_sched #(
  parameter int NUM_PORTS    = 4,
  parameter int CREDIT_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] requests [NUM_PORTS],
  input  logic [NUM_PORTS-1:0] req_tail,
  input  logic [NUM_PORTS-1:0] credit_return,
  output logic [NUM_PORTS-1:0] grants [NUM_PORTS],
  output logic [NUM_PORTS-1:0] out_locked,
  output logic                 credit_err
);

  localparam int CNT_W = $clog2(CREDIT_DEPTH + 1);
  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(CREDIT_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_PORTS - 1);

  logic [NUM_PORTS-1:0] lock_q, lock_d;
  logic [IDX_W-1:0]     owner_q  [NUM_PORTS];
  logic [IDX_W-1:0]     owner_d  [NUM_PORTS];
  logic [IDX_W-1:0]     ptr_q    [NUM_PORTS];
  logic [IDX_W-1:0]     ptr_d    [NUM_PORTS];
  logic [CNT_W-1:0]     credit_q [NUM_PORTS];
  logic [CNT_W-1:0]     credit_d [NUM_PORTS];
  logic                 credit_err_q, credit_err_d;

  logic [NUM_PORTS-1:0] req_ok;
  logic [NUM_PORTS-1:0] out_gnt;
  logic [IDX_W-1:0]     gnt_idx  [NUM_PORTS];

  // Multi-hot request vectors are treated as no request at all.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) req_ok[i] = $onehot(requests[i]);
  end

  // Arbitration: a locked output serves only its owner, even if that leaves a bubble.
  always_comb begin
    logic [IDX_W-1:0] idx;
    idx     = '0;
    out_gnt = '0;
    for (int i = 0; i < NUM_PORTS; i++) grants[i] = '0;
    for (int j = 0; j < NUM_PORTS; j++) gnt_idx[j] = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (credit_q[j] != '0) begin
        if (lock_q[j]) begin
          if (req_ok[owner_q[j]] && requests[owner_q[j]][j]) begin
            out_gnt[j] = 1'b1;
            gnt_idx[j] = owner_q[j];
          end
        end else begin
          for (int off = 0; off < NUM_PORTS; off++) begin
            idx = IDX_W'((int'(ptr_q[j]) + off) % NUM_PORTS);
            if (!out_gnt[j] && req_ok[idx] && requests[idx][j]) begin
              out_gnt[j] = 1'b1;
              gnt_idx[j] = idx;
            end
          end
        end
      end
      if (out_gnt[j]) grants[gnt_idx[j]][j] = 1'b1;
    end
  end

  always_comb begin
    lock_d       = lock_q;
    credit_err_d = credit_err_q;
    for (int j = 0; j < NUM_PORTS; j++) begin
      owner_d[j]  = owner_q[j];
      ptr_d[j]    = ptr_q[j];
      credit_d[j] = credit_q[j];
    end
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (out_gnt[j]) begin
        if (req_tail[gnt_idx[j]]) begin
          lock_d[j] = 1'b0;
          ptr_d[j]  = (gnt_idx[j] == LAST_IDX) ? '0 : gnt_idx[j] + 1'b1;
        end else begin
          lock_d[j]  = 1'b1;
          owner_d[j] = gnt_idx[j];
        end
      end
      // A grant and a return in the same cycle cancel out.
      if (out_gnt[j] && !credit_return[j]) begin
        credit_d[j] = credit_q[j] - 1'b1;
      end else if (!out_gnt[j] && credit_return[j]) begin
        if (credit_q[j] == CREDIT_MAX) credit_err_d = 1'b1;
        else                           credit_d[j] = credit_q[j] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q       <= '0;
      credit_err_q <= 1'b0;
      for (int j = 0; j < NUM_PORTS; j++) begin
        owner_q[j]  <= '0;
        ptr_q[j]    <= '0;
        credit_q[j] <= CREDIT_MAX;
      end
    end else begin
      lock_q       <= lock_d;
      credit_err_q <= credit_err_d;
      for (int j = 0; j < NUM_PORTS; j++) begin
        owner_q[j]  <= owner_d[j];
        ptr_q[j]    <= ptr_d[j];
        credit_q[j] <= credit_d[j];
      end
    end
  end

  assign out_locked = lock_q;
  assign credit_err = credit_err_q;

endmodule

// File: doc/sw_alloc_sched.md
SW_ALLOC_SCHED -- requirements
Module: sw_alloc_sched

Interface
REQ-001 The block SHALL have parameter NUM_PORTS, default 4, giving the number of input ports and output ports.
REQ-002 The block SHALL have parameter CREDIT_DEPTH, default 4, giving the downstream buffer slots per output; counter width CNT_W = $clog2(CREDIT_DEPTH+1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 requests  input  [NUM_PORTS-1:0] x NUM_PORTS (unpacked, one per input)  one-hot requested output port per input; all-zero means no request.
REQ-006 req_tail  input  NUM_PORTS  bit i marks the current flit of input i as a packet tail (single-flit packets assert it with head).
REQ-007 credit_return  input  NUM_PORTS  bit j returns one credit to output j this cycle.
REQ-008 grants  output  [NUM_PORTS-1:0] x NUM_PORTS (unpacked, one per input)  one-hot granted output per input; combinational in the same cycle as the request.
REQ-009 out_locked  output  NUM_PORTS  bit j high while output j is held by an in-progress packet.
REQ-010 credit_err  output  1  sticky flag, set on credit overflow.

Function
REQ-011 Per-output state: lock flag, lock owner (input index), round-robin pointer (input index), and credit counter (CNT_W bits).
REQ-012 A request vector with more than one bit set is illegal and SHALL be ignored: no grant and no state change for that input.
REQ-013 Output j SHALL be eligible only if credit[j] > 0.
REQ-014 Output j, locked to owner k and eligible: grant k iff requests[k][j]=1; no other input SHALL be granted j, even when k is idle (bubble).
REQ-015 Output j, unlocked and eligible: grant the first requesting input found searching from pointer[j] upward, modulo NUM_PORTS.
REQ-016 Each input SHALL receive at most one grant bit per cycle; each output SHALL be granted to at most one input per cycle.
REQ-017 On grant of j to i with req_tail[i]=0: set lock[j], owner[j]=i at the clock edge.
REQ-018 On grant of j to i with req_tail[i]=1: clear lock[j], set pointer[j]=(i+1) mod NUM_PORTS at the clock edge.
REQ-019 Pointer SHALL NOT move on non-tail grants or on idle cycles.
REQ-020 credit[j] next value: -1 on a grant only, +1 on credit_return[j] only, unchanged when both or neither occur.
REQ-021 credit_return[j] with credit[j]=CREDIT_DEPTH and no same-cycle grant: counter holds at CREDIT_DEPTH and credit_err is set.
REQ-022 Counter SHALL never go below 0; this holds by REQ-013.
REQ-023 out_locked[j] SHALL equal the registered lock[j].
REQ-024 grants SHALL be purely combinational from the current inputs and registered state; the block introduces zero cycles of request-to-grant latency.

Reset
REQ-025 While reset=1 at a rising edge: all locks cleared, owners=0, pointers=0, credits=CREDIT_DEPTH, credit_err=0.
REQ-026 Reset asserted mid-packet SHALL abandon the lock; the next cycle arbitrates from pointer 0.
REQ-027 During the reset cycle, grants SHALL reflect the pre-reset state combinationally; upstream logic ignores grants while reset=1.

Verification (NUM_PORTS=4, CREDIT_DEPTH=4)
REQ-028 Inputs 0–3 all request output 2 with tail=1 for 4 cycles after reset -> grants go to inputs 0, 1, 2, 3 in turn; pointer[2] returns to 0.
REQ-029 Input 1 sends a 3-flit packet to output 0 (tail on flit 3) and input 2 also requests output 0; input 1 idles one cycle mid-packet -> input 2 gets no grant until the cycle after the tail of input 1 is granted; out_locked[0]=1 across the bubble.
REQ-030 Single-flit grants to output 3 on 4 consecutive cycles with no returns -> credit reaches 0 and a 5th request gets no grant; credit_return[3] pulse -> grant on the following cycle.
REQ-031 Grant and credit_return on output 1 in the same cycle -> credit unchanged; credit_return on output 1 at credit=4 with no grant -> credit stays 4 and credit_err=1 until reset.
REQ-032 Input 0 request vector 4'b0101 -> no grant, no state change; inputs to distinct outputs 0, 1, 2, 3 -> all four granted in the same cycle.
REQ-033 Reset asserted while output 2 is locked to input 3 -> next cycle out_locked=0, credits=4, and input 0 wins output 2 over input 3.
